// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared types, defaults and width helper for the SIPO deserializer
package sipo_pkg;

  localparam int SIPO_DEFAULT_WIDTH = 8;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_STALL = 1'b1
  } sipo_state_e;

  function automatic int sipo_cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// rtl/sipo_shift_core.sv - shift register and bit counter with direction, flush and reset
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH     = SIPO_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = sipo_cnt_w(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_accept,
  input  logic             i_bit,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_sh,
  output logic [CW-1:0]    o_cnt,
  output logic             o_last_bit
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_sh;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_shifted;
  logic             w_at_last;

  assign w_at_last = (r_cnt == LAST);

  // Shift the incoming bit in from the side selected by MSB_FIRST
  always_comb begin
    w_shifted = r_sh;
    if (MSB_FIRST) w_shifted = {r_sh[WIDTH-2:0], i_bit};
    else           w_shifted = {i_bit, r_sh[WIDTH-1:1]};
  end

  // Flush wins over an accepted bit, so a bit offered alongside flush is dropped
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (i_accept) begin
      r_sh  <= w_shifted;
      r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_sh       = r_sh;
  assign o_cnt      = r_cnt;
  assign o_last_bit = i_accept && !i_flush && w_at_last;

endmodule

// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - serial-in parallel-out deserializer with one-entry output register
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = SIPO_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  localparam int CW       = sipo_cnt_w(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_bit_in,
  input  logic             i_bit_valid,
  output logic             o_bit_ready,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_word_out,
  output logic             o_word_valid,
  input  logic             i_word_ready,
  output logic [CW-1:0]    o_bit_count
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_word;
  logic             r_word_valid;
  logic [WIDTH-1:0] w_sh;
  logic [CW-1:0]    w_cnt;
  logic             w_last_bit;
  logic             w_accept;
  logic [WIDTH-1:0] w_done;
  sipo_state_e      w_state;

  sipo_shift_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_accept   (w_accept),
    .i_bit      (i_bit_in),
    .i_flush    (i_flush),
    .o_sh       (w_sh),
    .o_cnt      (w_cnt),
    .o_last_bit (w_last_bit)
  );

  // Stall only when the final bit would complete a word while the output is still occupied
  always_comb begin
    w_state = ST_ACCUM;
    if (w_cnt == LAST && r_word_valid) w_state = ST_STALL;
  end

  assign o_bit_ready = (w_state == ST_ACCUM);
  assign w_accept    = i_bit_valid && o_bit_ready;

  // Completed word is the current partial word with the final bit applied
  always_comb begin
    w_done = w_sh;
    if (MSB_FIRST) w_done = {w_sh[WIDTH-2:0], i_bit_in};
    else           w_done = {i_bit_in, w_sh[WIDTH-1:1]};
  end

  // Output register: load on word completion, drop valid on take; data is held after a take
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else if (w_last_bit) begin
      r_word       <= w_done;
      r_word_valid <= 1'b1;
    end else if (r_word_valid && i_word_ready) begin
      r_word_valid <= 1'b0;
    end
  end

  assign o_word_out   = r_word;
  assign o_word_valid = r_word_valid;
  assign o_bit_count  = w_cnt;

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb/tb_sipo_deserializer.sv - self-checking bench for sipo_deserializer, both bit orders
module tb_sipo_deserializer;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst, bit_in, bit_valid, flush, word_ready;
  logic       m_bit_ready, l_bit_ready;
  logic [7:0] m_word_out, l_word_out;
  logic       m_word_valid, l_word_valid;
  logic [2:0] m_bit_count, l_bit_count;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: partial bits as a list, plus the pending word for each bit order
  logic       q_bits[$];
  logic       e_valid;
  logic [7:0] e_msb, e_lsb;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .i_clk(clk), .i_rst(rst), .i_bit_in(bit_in), .i_bit_valid(bit_valid),
    .o_bit_ready(m_bit_ready), .i_flush(flush), .o_word_out(m_word_out),
    .o_word_valid(m_word_valid), .i_word_ready(word_ready), .o_bit_count(m_bit_count)
  );

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .i_clk(clk), .i_rst(rst), .i_bit_in(bit_in), .i_bit_valid(bit_valid),
    .o_bit_ready(l_bit_ready), .i_flush(flush), .o_word_out(l_word_out),
    .o_word_valid(l_word_valid), .i_word_ready(word_ready), .o_bit_count(l_bit_count)
  );

  function automatic logic e_ready();
    return !(q_bits.size() == W - 1 && e_valid);
  endfunction

  function automatic logic [2:0] e_count();
    return 3'(q_bits.size());
  endfunction

  // Apply one cycle of inputs, advance the model, then move to just after the edge
  task automatic drive(input logic r, input logic v, input logic b, input logic f, input logic wr);
    logic rdy;
    rst = r; bit_valid = v; bit_in = b; flush = f; word_ready = wr;
    rdy = e_ready();
    if (r) begin
      q_bits.delete(); e_valid = 1'b0; e_msb = '0; e_lsb = '0;
    end else begin
      if (e_valid && wr) e_valid = 1'b0;
      if (!f && v && rdy) begin
        q_bits.push_back(b);
        if (q_bits.size() == W) begin
          e_msb = '0; e_lsb = '0;
          for (int i = 0; i < W; i++) begin
            e_msb = (e_msb << 1) | 8'(q_bits[i]);
            e_lsb = e_lsb | (8'(q_bits[i]) << i);
          end
          e_valid = 1'b1;
          q_bits.delete();
        end
      end else if (f) begin
        q_bits.delete();
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] val, input logic wr);
    for (int i = 7; i >= 0; i--) drive(1'b0, 1'b1, val[i], 1'b0, wr);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++)
      drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    n_total++; if (m_word_valid !== 1'b0) $display("FAIL reset_msb_valid got=%b exp=0", m_word_valid); else n_pass++;
    n_total++; if (m_word_out !== 8'h00) $display("FAIL reset_msb_word got=%h exp=00", m_word_out); else n_pass++;
    n_total++; if (m_bit_ready !== 1'b1) $display("FAIL reset_msb_ready got=%b exp=1", m_bit_ready); else n_pass++;
    n_total++; if (m_bit_count !== 3'd0) $display("FAIL reset_msb_count got=%0d exp=0", m_bit_count); else n_pass++;
    n_total++; if ({l_word_valid, l_word_out, l_bit_ready, l_bit_count} !== {1'b0, 8'h00, 1'b1, 3'd0})
      $display("FAIL reset_lsb got=%b/%h/%b/%0d exp=0/00/1/0", l_word_valid, l_word_out, l_bit_ready, l_bit_count);
    else n_pass++;
  endtask

  task automatic test_stream();
    logic [7:0] s;
    s = 8'b1011_0010;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, s[7-i], 1'b0, 1'b1);
      if (i < 7) begin
        n_total++;
        if (m_word_valid !== 1'b0 || m_bit_count !== e_count())
          $display("FAIL stream_partial i=%0d got v=%b cnt=%0d exp v=0 cnt=%0d", i, m_word_valid, m_bit_count, e_count());
        else n_pass++;
      end
    end
    n_total++; if (m_word_valid !== 1'b1 || m_word_out !== 8'hB2) $display("FAIL stream_msb got=%b/%h exp=1/b2", m_word_valid, m_word_out); else n_pass++;
    n_total++; if (l_word_valid !== 1'b1 || l_word_out !== 8'h4D) $display("FAIL stream_lsb got=%b/%h exp=1/4d", l_word_valid, l_word_out); else n_pass++;
    n_total++; if (l_word_out !== e_lsb) $display("FAIL stream_lsb_model got=%h exp=%h", l_word_out, e_lsb); else n_pass++;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_total++; if (m_word_valid !== 1'b0 || l_word_valid !== 1'b0) $display("FAIL stream_one_cycle got=%b%b exp=00", m_word_valid, l_word_valid); else n_pass++;
    n_total++; if (m_word_out !== 8'hB2) $display("FAIL stream_hold got=%h exp=b2", m_word_out); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [7:0] b;
    b = 8'h3C;
    send_byte(8'hA5, 1'b0);
    for (int i = 7; i >= 1; i--) drive(1'b0, 1'b1, b[i], 1'b0, 1'b0);
    n_total++; if (m_bit_ready !== 1'b0 || m_bit_count !== 3'd7) $display("FAIL bp_stall got rdy=%b cnt=%0d exp rdy=0 cnt=7", m_bit_ready, m_bit_count); else n_pass++;
    drive(1'b0, 1'b1, b[0], 1'b0, 1'b0);
    n_total++; if (m_word_out !== 8'hA5 || m_bit_count !== 3'd7 || m_word_valid !== 1'b1)
      $display("FAIL bp_hold got=%h cnt=%0d v=%b exp=a5 cnt=7 v=1", m_word_out, m_bit_count, m_word_valid);
    else n_pass++;
    drive(1'b0, 1'b1, b[0], 1'b0, 1'b1);
    n_total++; if (m_word_valid !== 1'b0 || m_bit_ready !== 1'b1 || m_bit_count !== 3'd7)
      $display("FAIL bp_take got v=%b rdy=%b cnt=%0d exp v=0 rdy=1 cnt=7", m_word_valid, m_bit_ready, m_bit_count);
    else n_pass++;
    drive(1'b0, 1'b1, b[0], 1'b0, 1'b0);
    n_total++; if (m_word_valid !== 1'b1 || m_word_out !== 8'h3C) $display("FAIL bp_final got=%b/%h exp=1/3c", m_word_valid, m_word_out); else n_pass++;
    n_total++; if (l_word_out !== e_lsb) $display("FAIL bp_lsb got=%h exp=%h", l_word_out, e_lsb); else n_pass++;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    n_total++; if (m_bit_count !== 3'd5) $display("FAIL flush_pre got=%0d exp=5", m_bit_count); else n_pass++;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    n_total++; if (m_bit_count !== 3'd0 || l_bit_count !== 3'd0) $display("FAIL flush_count got=%0d/%0d exp=0", m_bit_count, l_bit_count); else n_pass++;
    send_byte(8'h81, 1'b0);
    n_total++; if (m_word_valid !== 1'b1 || m_word_out !== 8'h81) $display("FAIL flush_msb got=%b/%h exp=1/81", m_word_valid, m_word_out); else n_pass++;
    n_total++; if (l_word_out !== 8'h81) $display("FAIL flush_lsb got=%h exp=81", l_word_out); else n_pass++;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    send_byte(8'h55, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'($urandom), 1'b0, 1'b0);
    n_total++; if (m_word_valid !== 1'b1 || m_bit_count !== 3'd3) $display("FAIL rstmid_pre got v=%b cnt=%0d exp v=1 cnt=3", m_word_valid, m_bit_count); else n_pass++;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    n_total++; if (m_word_valid !== 1'b0 || m_bit_count !== 3'd0 || m_bit_ready !== 1'b1 || m_word_out !== 8'h00)
      $display("FAIL rstmid_clear got v=%b cnt=%0d rdy=%b w=%h exp 0/0/1/00", m_word_valid, m_bit_count, m_bit_ready, m_word_out);
    else n_pass++;
    send_byte(8'h0F, 1'b0);
    n_total++; if (m_word_valid !== 1'b1 || m_word_out !== 8'h0F) $display("FAIL rstmid_msb got=%b/%h exp=1/0f", m_word_valid, m_word_out); else n_pass++;
    n_total++; if (l_word_out !== 8'hF0) $display("FAIL rstmid_lsb got=%h exp=f0", l_word_out); else n_pass++;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_gapped();
    logic [7:0] s;
    s = 8'hC3;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) drive(1'b0, 1'b1, s[7 - i/2], 1'b0, 1'b0);
      else            drive(1'b0, 1'b0, 1'($urandom), 1'b0, 1'b0);
      if (i < 15) begin
        n_total++;
        if (m_bit_count !== 3'((i/2 + 1) % 8)) $display("FAIL gap_count i=%0d got=%0d exp=%0d", i, m_bit_count, (i/2 + 1) % 8);
        else n_pass++;
      end
    end
    n_total++; if (m_word_valid !== 1'b1 || m_word_out !== 8'hC3) $display("FAIL gap_msb got=%b/%h exp=1/c3", m_word_valid, m_word_out); else n_pass++;
    n_total++; if (l_word_out !== e_lsb) $display("FAIL gap_lsb got=%h exp=%h", l_word_out, e_lsb); else n_pass++;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive(1'(($urandom % 64) == 0), 1'(($urandom % 4) != 0), 1'($urandom),
            1'(($urandom % 16) == 0), 1'(($urandom % 3) == 0));
      n_total++;
      if ({m_word_valid, m_word_out, m_bit_ready, m_bit_count} !== {e_valid, e_msb, e_ready(), e_count()})
        $display("FAIL rand_msb cyc=%0d got=%b/%h/%b/%0d exp=%b/%h/%b/%0d", i, m_word_valid, m_word_out, m_bit_ready,
                 m_bit_count, e_valid, e_msb, e_ready(), e_count());
      else n_pass++;
      n_total++;
      if ({l_word_valid, l_word_out, l_bit_ready, l_bit_count} !== {e_valid, e_lsb, e_ready(), e_count()})
        $display("FAIL rand_lsb cyc=%0d got=%b/%h/%b/%0d exp=%b/%h/%b/%0d", i, l_word_valid, l_word_out, l_bit_ready,
                 l_bit_count, e_valid, e_lsb, e_ready(), e_count());
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; flush = 1'b0; word_ready = 1'b0;
    e_valid = 1'b0; e_msb = '0; e_lsb = '0;
    @(posedge clk); #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_gapped();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sipo_deserializer.md
# sipo_deserializer

Serial-in, parallel-out deserializer directly downstream of the single-bit `d_flipflop` register stage. It consumes the registered bit stream one bit per accepted cycle and assembles WIDTH-bit words. Completed words are presented through a one-entry output register with a valid/ready handshake. It is the first multi-bit consumer in the flip-flop chain and the template for later shift-register blocks.

## Interface
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1: the first bit received lands in word_out[WIDTH-1]; 0: the first bit received lands in word_out[0].

- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- bit_in  input  1  serial data; normally the q of the upstream d_flipflop stage.
- bit_valid  input  1  bit_in is meaningful this cycle.
- bit_ready  output  1  block accepts a bit this cycle.
- flush  input  1  discard any partial word.
- word_out  output  WIDTH  assembled word; stable while word_valid is high.
- word_valid  output  1  word_out holds an unconsumed word.
- word_ready  input  1  consumer takes word_out this cycle.
- bit_count  output  $clog2(WIDTH)  number of bits of the current partial word.

## Operation
- Bit accept: bit_valid && bit_ready at a rising edge. Word take: word_valid && word_ready at a rising edge.
- Internal state:
  - shift register sh[WIDTH-1:0].
  - counter cnt, which drives bit_count.
  - output register plus its valid flag.
- FSM, derived from cnt and word_valid:
  - ACCUM: cnt < WIDTH-1, or word_valid = 0.
  - STALL: cnt == WIDTH-1 and word_valid = 1.
- bit_ready = !(cnt == WIDTH-1 && word_valid). It is a function of registered state only, with no combinational path from word_ready or bit_valid.
- Accepted bit with cnt < WIDTH-1:
  - MSB_FIRST=1: sh <= {sh[WIDTH-2:0], bit_in}.
  - MSB_FIRST=0: sh <= {bit_in, sh[WIDTH-1:1]}.
  - cnt increments.
- Accepted bit with cnt == WIDTH-1:
  - The completed word (sh with the new bit applied) loads the output register.
  - word_valid <= 1; cnt wraps to 0.
  - This is legal only when word_valid = 0, which bit_ready guarantees.
- Word take with no simultaneous load: word_valid <= 0. word_out keeps its last value; it is not cleared.
- Word take and completed-word load in the same cycle is impossible by construction, because bit_ready is 0 when word_valid = 1 at cnt == WIDTH-1.
- flush:
  - cnt <= 0 and sh <= 0 on the next edge.
  - A bit accepted in the same cycle is dropped. The source sees it as consumed.
  - The output register and word_valid are untouched; a word take in the same cycle proceeds normally.
- rst (priority over everything):
  - sh = 0, cnt = 0, word_out = 0, word_valid = 0.
  - A pending word is lost.
  - Combinational outputs after reset: bit_ready = 1, bit_count = 0.

## Timing
- Latency: the word appears (word_valid = 1) in the cycle after the edge that accepts its WIDTH-th bit.
- Throughput: one bit per cycle sustained while the consumer takes each word within WIDTH-1 cycles of it appearing. Otherwise the block holds the stream in STALL.
- Back-to-back: when the word is taken at edge N in STALL, bit_ready rises after edge N, and the final bit can be accepted at edge N+1.
- word_out and word_valid change only at rising edges and are glitch-free for a registered consumer.
- Reset mid-word or mid-handshake: outputs take their reset values after the edge on which rst is sampled high. No bit or word accepted on that edge has any effect.

## Structure
- Shared package sipo_pkg:
  - SIPO_DEFAULT_WIDTH = 8.
  - Function sipo_cnt_w(width) returning $clog2(width), used for bit_count and cnt.
- One sub-module, sipo_shift_core: shift register plus counter, with MSB_FIRST direction, flush and rst. It exports sh, cnt and a last_bit strobe.
- Top level owns the output register, word_valid and the bit_ready logic.

## Test plan
WIDTH=8 for all scenarios unless stated.
- Reset: hold rst 2 cycles with random inputs -> word_valid=0, word_out=0x00, bit_ready=1, bit_count=0.
- MSB_FIRST=1, stream 1,0,1,1,0,0,1,0 on consecutive cycles, word_ready=1 -> word_out=0xB2 with word_valid high for exactly 1 cycle, after the 8th accept. Same stream with MSB_FIRST=0 -> word_out=0x4D.
- Backpressure: word_ready=0; send 0xA5 then the first 7 bits of 0x3C -> bit_ready=0 at bit_count=7 and word_out stays 0xA5. Raise word_ready for 1 cycle -> 0xA5 taken, bit_ready=1 the next cycle, and the final bit yields word_out=0x3C.
- Flush: after 5 bits of 0xFF, assert flush together with a valid bit -> bit_count=0 next cycle. A following full 0x81 yields 0x81, with no leftover 1s from the flushed bits.
- Reset mid-word and with a pending word: word_valid=1 (0x55) plus 3 partial bits; pulse rst -> word_valid=0, bit_count=0. The next 8 bits of 0x0F yield 0x0F.
- Gapped input: bit_valid toggling 1/0 while sending 0xC3 -> bit_count advances only on accepted bits and word_out=0xC3.
